// File: rtl/mainfsm_pkg.sv
// Shared controller definitions: state encodings, opcode classes and the
// datapath select values driven by the main control FSM.
package mainfsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    localparam logic SRCA_REG = 1'b0;
    localparam logic SRCA_PC  = 1'b1;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/mainfsm_flopr.sv
// Resettable register; synchronous active-high reset clears it to zero.
module flopr #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/mainfsm.sv
// Multicycle main control FSM (Moore): outputs decode the state register only;
// Op/Funct steer the next state in DECODE and MEMADR.
module mainfsm
    import mainfsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp
);

    logic [3:0] state_q;
    state_t     state;
    state_t     next_state;
    logic       unused_funct;

    assign unused_funct = ^Funct[4:1];

    // FETCH encodes as zero, so the register's reset value is FETCH.
    flopr #(.DATA_W(4)) u_state_reg (
        .clk   (clk),
        .reset (reset),
        .d     (next_state),
        .q     (state_q)
    );

    assign state = state_t'(state_q);

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (Op)
                    OP_DP:   next_state = Funct[5] ? EXECUTEI : EXECUTER;
                    OP_MEM:  next_state = MEMADR;
                    OP_BR:   next_state = BRANCH;
                    default: next_state = UNKNOWN;
                endcase
            end
            MEMADR:   next_state = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    next_state = MEMWB;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = ADR_PC;
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_WD;
        ResultSrc = RES_ALUOUT;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        case (state)
            FETCH: begin
                AdrSrc    = ADR_PC;
                IRWrite   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                NextPC    = 1'b1;
            end
            // PC+8 is formed here so R15 reads correctly during execute.
            DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
            end
            MEMRD: begin
                ResultSrc = RES_ALUOUT;
                AdrSrc    = ADR_ALUOUT;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
            end
            MEMWR: begin
                ResultSrc = RES_ALUOUT;
                AdrSrc    = ADR_ALUOUT;
                MemW      = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_WD;
                ALUOp   = 1'b1;
            end
            EXECUTEI: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                ALUOp   = 1'b1;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegW      = 1'b1;
            end
            BRANCH: begin
                ALUSrcA   = SRCA_REG;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                Branch    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mainfsm.sv
// Scoreboard bench for mainfsm: each clock edge issued pushes the expected
// output vector; a negedge monitor pops and compares against the DUT.
module tb_mainfsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp;
    logic [1:0] ALUSrcB, ResultSrc;

    mainfsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp)
    );

    always #5 clk = ~clk;

    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp}
    localparam logic [11:0] E_FETCH  = 12'b1_0_1_10_10_1_0_0_0_0;
    localparam logic [11:0] E_DECODE = 12'b0_0_1_10_10_0_0_0_0_0;
    localparam logic [11:0] E_MEMADR = 12'b0_0_0_01_00_0_0_0_0_0;
    localparam logic [11:0] E_MEMRD  = 12'b0_1_0_00_00_0_0_0_0_0;
    localparam logic [11:0] E_MEMWB  = 12'b0_0_0_00_01_0_1_0_0_0;
    localparam logic [11:0] E_MEMWR  = 12'b0_1_0_00_00_0_0_1_0_0;
    localparam logic [11:0] E_EXR    = 12'b0_0_0_00_00_0_0_0_0_1;
    localparam logic [11:0] E_EXI    = 12'b0_0_0_01_00_0_0_0_0_1;
    localparam logic [11:0] E_ALUWB  = 12'b0_0_0_00_00_0_1_0_0_0;
    localparam logic [11:0] E_BRANCH = 12'b0_0_0_01_10_0_0_0_1_0;
    localparam logic [11:0] E_UNK    = 12'b0_0_0_00_00_0_0_0_0_0;

    typedef struct {
        string       name;
        logic [11:0] vec;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [11:0] dut_vec;
    assign dut_vec = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                      NextPC, RegW, MemW, Branch, ALUOp};

    // Monitor
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (dut_vec !== e.vec) begin
                n_bad++;
                $display("FAIL %s: outputs got %b want %b", e.name, dut_vec, e.vec);
            end
            n_cmp++;
            if ((RegW & MemW) !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_regw_memw_exclusive: RegW=%b MemW=%b want not both 1",
                         e.name, RegW, MemW);
            end
        end
    end

    task automatic step(input string name, input logic [11:0] vec);
        @(posedge clk);
        #1;
        q.push_back('{name, vec});
    endtask

    task automatic set_in(input logic [1:0] op, input logic [5:0] funct);
        Op    = op;
        Funct = funct;
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        set_in(2'b00, 6'b000000);

        // Reset held 3 edges, then an ADD register instruction.
        step("rst0", E_FETCH);
        step("rst1", E_FETCH);
        step("rst2", E_FETCH);
        reset = 1'b0;
        step("dp_decode", E_DECODE);
        step("dp_executer", E_EXR);
        step("dp_aluwb", E_ALUWB);
        step("dp_fetch", E_FETCH);

        // ADD immediate
        set_in(2'b00, 6'b100000);
        step("dpi_decode", E_DECODE);
        step("dpi_executei", E_EXI);
        step("dpi_aluwb", E_ALUWB);
        step("dpi_fetch", E_FETCH);

        // LDR: 5 cycles
        set_in(2'b01, 6'b000001);
        step("ldr_decode", E_DECODE);
        step("ldr_memadr", E_MEMADR);
        step("ldr_memrd", E_MEMRD);
        step("ldr_memwb", E_MEMWB);
        step("ldr_fetch", E_FETCH);

        // STR: 4 cycles
        set_in(2'b01, 6'b000000);
        step("str_decode", E_DECODE);
        step("str_memadr", E_MEMADR);
        step("str_memwr", E_MEMWR);
        step("str_fetch", E_FETCH);

        // Branch: 3 cycles
        set_in(2'b10, 6'b101011);
        step("br_decode", E_DECODE);
        step("br_branch", E_BRANCH);
        step("br_fetch", E_FETCH);

        // Undefined op: 3 cycles
        set_in(2'b11, 6'b111111);
        step("unk_decode", E_DECODE);
        step("unk_state", E_UNK);
        step("unk_fetch", E_FETCH);

        // Reset while in MEMRD aborts the load before MEMWB.
        set_in(2'b01, 6'b000001);
        step("abort_decode", E_DECODE);
        step("abort_memadr", E_MEMADR);
        step("abort_memrd", E_MEMRD);
        reset = 1'b1;
        step("abort_reset", E_FETCH);
        reset = 1'b0;
        set_in(2'b00, 6'b100000);
        step("post_decode", E_DECODE);
        step("post_executei", E_EXI);
        step("post_aluwb", E_ALUWB);
        step("post_fetch", E_FETCH);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mainfsm.md
# mainfsm

Multicycle main control FSM: sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath mux selects and the unconditioned write requests NextPC, RegW, MemW and Branch. Those requests feed the conditional-execution logic, which gates RegW/MemW with the registered condition result. It sits in the controller beside the ALU decoder and PC decoder, and is the producer end of that request interface.

## Interface
Parameters:
- none (state width fixed at 4 bits).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; forces FETCH on next edge.
- Op  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  in  6  instruction bits [25:20]: Funct[5] = I (immediate), Funct[0] = L (load) / S.
- IRWrite  out  1  load instruction register.
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUResult register.
- ALUSrcA  out  1  SrcA: 0 = register A, 1 = PC.
- ALUSrcB  out  2  SrcB: 00 = WriteData, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  Result: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- NextPC  out  1  unconditional PC write (PC+4).
- RegW  out  1  register write request, pre-condition.
- MemW  out  1  memory write request, pre-condition.
- Branch  out  1  branch request; ORed into the PC-select path.
- ALUOp  out  1  1 = ALU decoder uses Funct; 0 = force ADD.

## Operation
- Moore machine: all outputs are a pure decode of the state register. Op and Funct affect only the next state.
- Any output not listed for a state is 0.
- States and outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10 (R15 = PC+8).
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
  - MEMRD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: ResultSrc=00, AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.
  - UNKNOWN: all outputs 0.
- Transitions:
  - FETCH → DECODE.
  - DECODE: Op=00 → Funct[5] ? EXECUTEI : EXECUTER; Op=01 → MEMADR; Op=10 → BRANCH; Op=11 → UNKNOWN.
  - MEMADR: Funct[0] ? MEMRD : MEMWR.
  - MEMRD → MEMWB.
  - EXECUTER, EXECUTEI → ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN → FETCH.
- Illegal state encodings → FETCH. The decoder default must never latch.

## Timing
- Reset: state = FETCH on the first edge with reset=1. Outputs then show FETCH values: IRWrite=1, NextPC=1, all other outputs as listed for FETCH.
- Reset held: the FSM stays in FETCH. Reset asserted mid-instruction aborts it and the next state is FETCH, regardless of Op/Funct.
- Cycle counts:
  - Data-processing: 4 cycles (FETCH, DECODE, EXECUTE*, ALUWB).
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
  - Undefined: 3 cycles.
- Protocol contract with the downstream condition logic:
  - ALUOp=1, and therefore flag writes, occurs only in EXECUTE states.
  - RegW/MemW are asserted exactly one cycle after the state in which CondEx was evaluated (EXECUTE* → ALUWB, MEMADR → MEMWR, MEMRD → MEMWB). This matches the one-cycle CondEx register downstream.
  - RegW and MemW are never asserted in the same state.
- Op/Funct are sampled only in DECODE and MEMADR. IR is stable there because IRWrite=1 only in FETCH.

## Structure
- Shared controller package holds:
  - the 4-bit state encodings (FETCH=0 … UNKNOWN=10);
  - Op constants (OP_DP, OP_MEM, OP_BR);
  - select constants for AdrSrc, ALUSrcA, ALUSrcB and ResultSrc.
- The state register is the existing flopr sub-module at width 4 (synchronous reset to FETCH=0).
- Next-state logic and output decode are each a single combinational case in this module.

## Test plan
- Reset held 3 cycles, then released with Op=00, Funct=000000: states FETCH, FETCH, FETCH, DECODE, EXECUTER, ALUWB, FETCH. RegW=1 only in ALUWB, with ResultSrc=00.
- Op=00, Funct=100000 (ADD immediate): EXECUTEI shows ALUSrcB=01, ALUOp=1; ALUWB shows RegW=1.
- Op=01, Funct=000001 (LDR): MEMADR → MEMRD (AdrSrc=1) → MEMWB (ResultSrc=01, RegW=1), i.e. 5 cycles. With Funct=000000 (STR): MEMWR asserts MemW=1, AdrSrc=1; 4 cycles total.
- Op=10: BRANCH asserts Branch=1, ALUSrcB=01, ResultSrc=10, then FETCH. Op=11: UNKNOWN with all outputs 0, then FETCH.
- Reset asserted while in MEMRD: next state FETCH, MEMWB never entered, RegW stays 0.
- Across every path: IRWrite and NextPC are 1 only in FETCH, and RegW and MemW are never high together.
